des_blk_ctrl: RTL
=================

# des_blk_ctrl

Block-level sequencer that sits directly upstream of the DES coprocessor. It assembles 64-bit input blocks from 32-bit register writes and launches them with a one-cycle valid pulse. It holds the input stable while the coprocessor runs, captures the 64-bit result into a readable buffer, and maintains the CBC chaining IV across consecutive blocks. It also provides busy/done status and an optional completion watchdog.

## Interface
Parameters:
- TMO_CYCLES, 255: watchdog limit in hclk cycles from launch to cop_dout_valid. Used only when DES_CTRL_TMO_EN is defined.

Ports (clock and reset first):
- hclk  in  1  clock
- hresetn  in  1  reset: hresetn, asynchronous, active-low; clock hclk
- din_wr  in  1  write strobe for input block word
- din_hi_sel  in  1  1 selects din[63:32]; 0 selects din[31:0]
- wdata  in  32  write data for din_wr
- iv_load  in  1  load iv_in into the chaining IV register
- iv_in  in  64  initial IV
- cbc_en  in  1  chaining enable; drives cop_iv_sel
- dec  in  1  1 selects decrypt; drives cop_encrypt (coprocessor polarity: 1 = decrypt)
- start  in  1  launch pulse
- res_rd  in  1  result read strobe
- res_hi_sel  in  1  result word select
- rdata  out  32  result word, combinational mux of the result buffer
- busy  out  1  block in flight
- done  out  1  sticky completion flag
- err  out  1  sticky watchdog timeout flag
- cop_din  out  64  input block register
- cop_din_valid  out  1  one-cycle launch pulse
- cop_encrypt  out  1  equals the dec value latched at start
- cop_iv  out  64  chaining IV register
- cop_iv_sel  out  1  equals the cbc_en value latched at start
- cop_dout  in  64  coprocessor result (IV-corrected for CBC decrypt)
- cop_dout_valid  in  1  result valid

## Operation
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE → LAUNCH on start.
  - LAUNCH → WAIT unconditionally after 1 cycle.
  - WAIT → IDLE on cop_dout_valid, or on timeout.
- busy=1 in LAUNCH and WAIT. cop_din_valid=1 only in LAUNCH.
- At start, dec and cbc_en are latched into mode registers. cop_encrypt and cop_iv_sel are driven from these registers, so they stay constant while busy.
- din_wr writes the selected 32-bit half of cop_din in IDLE only. It is ignored while busy, because the coprocessor re-reads din during its first pass.
- iv_load is honoured in IDLE only. cop_iv must remain stable while busy, because the coprocessor XORs it combinationally into dout.
- Completion (cop_dout_valid sampled in WAIT), all at the same edge:
  - result buffer ← cop_dout
  - done ← 1
  - if cop_iv_sel=1: cop_iv ← cop_dout when encrypting (cop_encrypt=0), or cop_iv ← cop_din when decrypting (cop_encrypt=1, previous ciphertext).
- cop_dout_valid is ignored in IDLE and LAUNCH, so stale results cannot complete a new block.
- done is cleared by start, or by res_rd with res_hi_sel=1. res_rd with res_hi_sel=0 has no side effect.
- err is cleared only by start or reset.

## Timing
- Reset values:
  - state IDLE
  - busy, done, err, cop_din_valid, cop_encrypt, cop_iv_sel = 0
  - cop_din, cop_iv, result buffer = 0
  - rdata = 0
- start sampled at edge 0: cop_din_valid high during cycle 1, WAIT from edge 2.
- cop_dout_valid sampled at edge N: at N+1, result, done=1, busy=0, and the updated IV are all visible. The next start is accepted from N+1.
- start while busy: ignored.
- start with din_wr in the same IDLE cycle: the write lands at edge 0, and the launch carries the new data.
- start with iv_load in the same cycle: the IV is loaded, and the launch uses the new IV.
- start with res_rd(hi) in the same cycle: done=0.
- Completion and timeout in the same cycle: completion wins, err stays 0.
- hresetn low mid-operation: immediate return to the reset values. The coprocessor shares the same reset.

## Configuration
- DES_CTRL_TMO_EN defined:
  - An 8..16-bit counter (width covers TMO_CYCLES) clears at LAUNCH and increments in WAIT.
  - When it reaches TMO_CYCLES without cop_dout_valid: err ← 1, return to IDLE, result buffer and IV unchanged, done stays 0.
- DES_CTRL_TMO_EN undefined:
  - No counter. err is tied to 0, and WAIT persists until cop_dout_valid.

## Test plan
- Single-DES ECB: key 133457799BBCDFF1, write din 0123456789ABCDEF (lo then hi), start, cbc_en=0, dec=0 → one cop_din_valid pulse; rdata hi/lo = 85E81354 / 0F0AB405; done=1, busy=0.
- CBC encrypt of two blocks with iv_in 0000000000000000 → after block 1, cop_iv = ciphertext 1; block 2 result equals E(P2 ^ C1); decrypting both with the same iv_in returns P1 and P2.
- din_wr, iv_load and start asserted while busy → cop_din, cop_iv and state unchanged; exactly one completion.
- cop_dout_valid forced high during LAUNCH and in IDLE → no capture, done stays 0.
- With DES_CTRL_TMO_EN and TMO_CYCLES=8, cop_dout_valid held low → err=1 and busy=0 exactly 8 WAIT cycles after launch; the next start clears err.
- hresetn pulsed low during WAIT → all outputs return to their reset values immediately; a subsequent start completes normally.

Source files
------------

// File: rtl/des_blk_ctrl.sv
// Block sequencer in front of the DES coprocessor: assembles input blocks, launches them,
// captures results and keeps the CBC chaining IV. Optional watchdog: define DES_CTRL_TMO_EN.
module des_blk_ctrl #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        din_wr,
    input  logic        din_hi_sel,
    input  logic [31:0] wdata,
    input  logic        iv_load,
    input  logic [63:0] iv_in,
    input  logic        cbc_en,
    input  logic        dec,
    input  logic        start,
    input  logic        res_rd,
    input  logic        res_hi_sel,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] cop_din,
    output logic        cop_din_valid,
    output logic        cop_encrypt,
    output logic [63:0] cop_iv,
    output logic        cop_iv_sel,
    input  logic [63:0] cop_dout,
    input  logic        cop_dout_valid
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

    state_t      state;
    logic [63:0] res_buf;
    logic        tmo_hit_c;

    assign rdata = res_hi_sel ? res_buf[63:32] : res_buf[31:0];

`ifdef DES_CTRL_TMO_EN
    localparam int unsigned TMO_BITS = $clog2(TMO_CYCLES + 1);
    localparam int unsigned CNT_W    = (TMO_BITS < 8) ? 8 : ((TMO_BITS > 16) ? 16 : TMO_BITS);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    // Fires on the TMO_CYCLES-th WAIT cycle; the counter starts at 0 in the first one.
    assign tmo_hit_c = (tmo_cnt == CNT_W'(TMO_CYCLES - 1));
    assign err       = err_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                err_q <= 1'b0;
            end
            if (state == S_LAUNCH) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
                if (!cop_dout_valid && tmo_hit_c) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
`else
    assign tmo_hit_c = 1'b0;
    assign err       = 1'b0;
`endif

    // Sequencer: state, launch pulse, mode latches, data/IV registers and result capture.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            cop_din_valid <= 1'b0;
            cop_encrypt   <= 1'b0;
            cop_iv_sel    <= 1'b0;
            cop_din       <= '0;
            cop_iv        <= '0;
            res_buf       <= '0;
        end else begin
            cop_din_valid <= 1'b0;
            if (res_rd && res_hi_sel) begin
                done <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (din_wr) begin
                        if (din_hi_sel) begin
                            cop_din[63:32] <= wdata;
                        end else begin
                            cop_din[31:0] <= wdata;
                        end
                    end
                    if (iv_load) begin
                        cop_iv <= iv_in;
                    end
                    if (start) begin
                        state         <= S_LAUNCH;
                        busy          <= 1'b1;
                        cop_din_valid <= 1'b1;
                        done          <= 1'b0;
                        cop_encrypt   <= dec;
                        cop_iv_sel    <= cbc_en;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cop_dout_valid) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        res_buf <= cop_dout;
                        // Next IV is this ciphertext: the output when encrypting, the input when decrypting.
                        if (cop_iv_sel) begin
                            cop_iv <= cop_encrypt ? cop_din : cop_dout;
                        end
                    end else if (tmo_hit_c) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
